sdp_erdma_lat_buf: RTL and testbench

Read-response latency buffer with credit tracking for the SDP element-wise read DMA (ERDMA). It sits between the DMA interface and the ERDMA egress stage. Each accepted read request reserves one entry, and each response beat is held until egress pops it. Every pop returns one credit to the DMA interface, so the block can never receive more responses than it can store.

---
 rtl/sdp_erdma_pkg.sv | 20 ++
 rtl/sdp_erdma_lat_buf_if.sv | 35 +++
 rtl/sdp_erdma_lat_buf_ram.sv | 32 +++
 rtl/sdp_erdma_lat_buf.sv | 105 ++++++++++
 tb/tb_sdp_erdma_lat_buf.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/sdp_erdma_pkg.sv
// =============================================================================
// Module      : sdp_erdma_pkg
// Description : Shared constants and width helpers for the SDP ERDMA path.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

package sdp_erdma_pkg;

    localparam int DMA_RD_RSP_W    = 514;
    localparam int ERDMA_LAT_DEPTH = 64;

    // Pointer width for a power-of-two depth; count needs one more bit.
    function automatic int lat_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdp_erdma_lat_buf_if.sv
// =============================================================================
// Module      : sdp_erdma_lat_buf_if
// Description : Request/response/egress bundle of the ERDMA latency buffer.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

interface sdp_erdma_lat_buf_if
    import sdp_erdma_pkg::*;
#(
    parameter int WIDTH = DMA_RD_RSP_W
);
    logic             req_accept;
    logic             credit_avail;
    logic             wr_pvld;
    logic             wr_prdy;
    logic [WIDTH-1:0] wr_pd;
    logic             rd_pvld;
    logic             rd_prdy;
    logic [WIDTH-1:0] rd_pd;
    logic             cdt_pop;
    logic             credit_err;

    modport slave (
        input  req_accept, wr_pvld, wr_pd, rd_prdy,
        output credit_avail, wr_prdy, rd_pvld, rd_pd, cdt_pop, credit_err
    );

    modport master (
        output req_accept, wr_pvld, wr_pd, rd_prdy,
        input  credit_avail, wr_prdy, rd_pvld, rd_pd, cdt_pop, credit_err
    );
endinterface

`default_nettype wire

// File: rtl/sdp_erdma_lat_buf_ram.sv
// =============================================================================
// Module      : sdp_erdma_lat_buf_ram
// Description : Flop array, one synchronous write port, one async read port.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module sdp_erdma_lat_buf_ram #(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 514,
    parameter int ADDR_W = 6
) (
    input  wire logic              nvdla_core_clk,
    input  wire logic              we_i,
    input  wire logic [ADDR_W-1:0] waddr_i,
    input  wire logic [WIDTH-1:0]  wdata_i,
    input  wire logic [ADDR_W-1:0] raddr_i,
    output logic      [WIDTH-1:0]  rdata_o
);
    // Payload storage is deliberately left unreset; occupancy lives in the top.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge nvdla_core_clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

`default_nettype wire

// File: rtl/sdp_erdma_lat_buf.sv
// =============================================================================
// Module      : sdp_erdma_lat_buf
// Description : ERDMA read-response latency buffer with credit tracking.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module sdp_erdma_lat_buf
    import sdp_erdma_pkg::*;
#(
    parameter int DEPTH = ERDMA_LAT_DEPTH,
    parameter int WIDTH = DMA_RD_RSP_W
) (
    input  wire logic         nvdla_core_clk,
    input  wire logic         nvdla_core_rstn,
    sdp_erdma_lat_buf_if.slave bus
);
    localparam int                 c_PTR_W = lat_ptr_w(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic [c_CNT_W-1:0] reserved_q, reserved_d;
    logic               cdt_pop_q;
    logic               credit_err_q, credit_err_d;

    logic w_wr_fire, w_rd_fire, w_res_inc, w_res_dec;

    // Ready/valid come only from registered state: no same-cycle bypass.
    assign bus.wr_prdy      = (count_q != c_FULL);
    assign bus.rd_pvld      = (count_q != '0);
    assign bus.credit_avail = (reserved_q < c_FULL);
    assign bus.cdt_pop      = cdt_pop_q;
    assign bus.credit_err   = credit_err_q;

    assign w_wr_fire = bus.wr_pvld & bus.wr_prdy;
    assign w_rd_fire = bus.rd_pvld & bus.rd_prdy;
    assign w_res_inc = bus.req_accept & (reserved_q != c_FULL);
    assign w_res_dec = w_rd_fire & (reserved_q != '0);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        reserved_d   = reserved_q;
        credit_err_d = credit_err_q;

        if (w_wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;

        case ({w_wr_fire, w_rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case ({w_res_inc, w_res_dec})
            2'b10:   reserved_d = reserved_q + 1'b1;
            2'b01:   reserved_d = reserved_q - 1'b1;
            default: reserved_d = reserved_q;
        endcase

        // Overflowing request, dropped beat, or a beat that had no reservation.
        if ((bus.req_accept && (reserved_q == c_FULL)) ||
            (bus.wr_pvld && (count_q == c_FULL)) ||
            (w_wr_fire && (count_d > reserved_d))) begin
            credit_err_d = 1'b1;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            reserved_q   <= '0;
            cdt_pop_q    <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            reserved_q   <= reserved_d;
            cdt_pop_q    <= w_rd_fire;
            credit_err_q <= credit_err_d;
        end
    end

    sdp_erdma_lat_buf_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (c_PTR_W)
    ) u_ram (
        .nvdla_core_clk (nvdla_core_clk),
        .we_i           (w_wr_fire),
        .waddr_i        (wr_ptr_q),
        .wdata_i        (bus.wr_pd),
        .raddr_i        (rd_ptr_q),
        .rdata_o        (bus.rd_pd)
    );
endmodule

`default_nettype wire

// File: tb/tb_sdp_erdma_lat_buf.sv
// =============================================================================
// Module      : tb_sdp_erdma_lat_buf
// Description : Self-checking bench for the ERDMA latency buffer (DEPTH=4).
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_sdp_erdma_lat_buf;
    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic nvdla_core_clk  = 1'b0;
    logic nvdla_core_rstn = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: FIFO contents, reservation total, error and credit pulse.
    logic [WIDTH-1:0] mq[$];
    int               m_res = 0;
    bit               m_err = 1'b0;
    bit               m_cdt = 1'b0;

    sdp_erdma_lat_buf_if #(.WIDTH(WIDTH)) bus ();

    sdp_erdma_lat_buf #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .bus             (bus)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        mq.delete();
        m_res = 0;
        m_err = 1'b0;
        m_cdt = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, settle.
    task automatic tick(input bit req, input bit wv, input logic [WIDTH-1:0] wd, input bit rp);
        int sz;
        bit rd, wr;
        bus.req_accept = req;
        bus.wr_pvld    = wv;
        bus.wr_pd      = wd;
        bus.rd_prdy    = rp;
        sz = mq.size();
        rd = (sz != 0) && rp;
        wr = wv && (sz < DEPTH);
        if (req && m_res == DEPTH) m_err = 1'b1;
        if (wv && sz == DEPTH)     m_err = 1'b1;
        if (req && m_res < DEPTH)  m_res++;
        if (rd && m_res > 0)       m_res--;
        if (rd) void'(mq.pop_front());
        if (wr) mq.push_back(wd);
        if (wr && mq.size() > m_res) m_err = 1'b1;
        m_cdt = rd;
        @(posedge nvdla_core_clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req_accept = 1'b0;
        bus.wr_pvld    = 1'b0;
        bus.wr_pd      = '0;
        bus.rd_prdy    = 1'b0;
        nvdla_core_rstn = 1'b0;
        repeat (2) @(posedge nvdla_core_clk);
        #1;
        nvdla_core_rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.wr_prdy !== 1'b1) $display("FAIL reset_wr_prdy got=%b exp=1", bus.wr_prdy); else n_pass++;
        n_checks++; if (bus.credit_avail !== 1'b1) $display("FAIL reset_credit_avail got=%b exp=1", bus.credit_avail); else n_pass++;
        n_checks++; if (bus.rd_pvld !== 1'b0) $display("FAIL reset_rd_pvld got=%b exp=0", bus.rd_pvld); else n_pass++;
        n_checks++; if (bus.cdt_pop !== 1'b0) $display("FAIL reset_cdt_pop got=%b exp=0", bus.cdt_pop); else n_pass++;
        n_checks++; if (bus.credit_err !== 1'b0) $display("FAIL reset_credit_err got=%b exp=0", bus.credit_err); else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        repeat (3) tick(1'b1, 1'b0, 8'h00, 1'b0);
        n_checks++; if (dut.reserved_q !== 3'd3) $display("FAIL basic_reserved3 got=%0d exp=3", dut.reserved_q); else n_pass++;
        tick(1'b0, 1'b1, 8'h11, 1'b1);
        n_checks++; if (bus.rd_pvld !== 1'b1 || bus.rd_pd !== 8'h11) $display("FAIL basic_rd0 got=%b/%h exp=1/11", bus.rd_pvld, bus.rd_pd); else n_pass++;
        tick(1'b0, 1'b1, 8'h22, 1'b1);
        n_checks++; if (bus.rd_pd !== 8'h22 || bus.cdt_pop !== 1'b1) $display("FAIL basic_rd1 got=%h/%b exp=22/1", bus.rd_pd, bus.cdt_pop); else n_pass++;
        tick(1'b0, 1'b1, 8'h33, 1'b1);
        n_checks++; if (bus.rd_pd !== 8'h33 || bus.cdt_pop !== 1'b1) $display("FAIL basic_rd2 got=%h/%b exp=33/1", bus.rd_pd, bus.cdt_pop); else n_pass++;
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        n_checks++; if (bus.cdt_pop !== 1'b1 || bus.rd_pvld !== 1'b0) $display("FAIL basic_last_pop got=%b/%b exp=1/0", bus.cdt_pop, bus.rd_pvld); else n_pass++;
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        n_checks++; if (bus.cdt_pop !== 1'b0) $display("FAIL basic_cdt_idle got=%b exp=0", bus.cdt_pop); else n_pass++;
        n_checks++; if (dut.reserved_q !== 3'd0) $display("FAIL basic_reserved0 got=%0d exp=0", dut.reserved_q); else n_pass++;
    endtask

    task automatic test_credit_limit();
        do_reset();
        repeat (4) tick(1'b1, 1'b0, 8'h00, 1'b0);
        n_checks++; if (bus.credit_avail !== 1'b0) $display("FAIL limit_credit_avail got=%b exp=0", bus.credit_avail); else n_pass++;
        n_checks++; if (bus.credit_err !== 1'b0) $display("FAIL limit_err_early got=%b exp=0", bus.credit_err); else n_pass++;
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        n_checks++; if (bus.credit_err !== 1'b1) $display("FAIL limit_err got=%b exp=1", bus.credit_err); else n_pass++;
        n_checks++; if (dut.reserved_q !== 3'd4) $display("FAIL limit_reserved got=%0d exp=4", dut.reserved_q); else n_pass++;
    endtask

    task automatic test_full();
        logic [WIDTH-1:0] d[4];
        do_reset();
        repeat (4) tick(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            d[i] = WIDTH'($urandom);
            tick(1'b0, 1'b1, d[i], 1'b0);
        end
        n_checks++; if (bus.wr_prdy !== 1'b0 || bus.rd_pvld !== 1'b1) $display("FAIL full_flags got=%b/%b exp=0/1", bus.wr_prdy, bus.rd_pvld); else n_pass++;
        n_checks++; if (bus.rd_pd !== d[0]) $display("FAIL full_head got=%h exp=%h", bus.rd_pd, d[0]); else n_pass++;
        tick(1'b0, 1'b1, 8'hEE, 1'b1);
        n_checks++; if (bus.credit_err !== 1'b1) $display("FAIL full_drop_err got=%b exp=1", bus.credit_err); else n_pass++;
        n_checks++; if (dut.count_q !== 3'd3 || bus.wr_prdy !== 1'b1) $display("FAIL full_after got=%0d/%b exp=3/1", dut.count_q, bus.wr_prdy); else n_pass++;
        n_checks++; if (bus.rd_pd !== d[1] || bus.cdt_pop !== 1'b1) $display("FAIL full_next got=%h/%b exp=%h/1", bus.rd_pd, bus.cdt_pop, d[1]); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] sent[20];
        int n_req = 0, n_wr = 0, n_pop = 0, n_cdt = 0;
        bit req, wv, rp;
        logic [WIDTH-1:0] wd;
        do_reset();
        for (int c = 0; c < 600 && n_pop < 20; c++) begin
            n_checks++; if (bus.rd_pvld !== (mq.size() != 0)) $display("FAIL wrap_rd_pvld cyc=%0d got=%b exp=%b", c, bus.rd_pvld, mq.size() != 0); else n_pass++;
            n_checks++; if (bus.credit_avail !== (m_res < DEPTH)) $display("FAIL wrap_credit_avail cyc=%0d got=%b exp=%b", c, bus.credit_avail, m_res < DEPTH); else n_pass++;
            n_checks++; if (bus.cdt_pop !== m_cdt) $display("FAIL wrap_cdt_pop cyc=%0d got=%b exp=%b", c, bus.cdt_pop, m_cdt); else n_pass++;
            if (bus.cdt_pop === 1'b1) n_cdt++;
            req = ($urandom_range(0, 1) == 1) && (m_res < DEPTH) && (n_req < 20);
            wv  = ($urandom_range(0, 3) != 0) && (m_res > mq.size()) && (n_wr < 20);
            rp  = ($urandom_range(0, 2) != 0);
            wd  = WIDTH'($urandom);
            if (wv) begin
                sent[n_wr] = wd;
                n_wr++;
            end
            if (req) n_req++;
            if (rp && mq.size() != 0) begin
                n_checks++; if (bus.rd_pd !== sent[n_pop]) $display("FAIL wrap_order idx=%0d got=%h exp=%h", n_pop, bus.rd_pd, sent[n_pop]); else n_pass++;
                n_pop++;
            end
            tick(req, wv, wd, rp);
        end
        if (bus.cdt_pop === 1'b1) n_cdt++;
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        n_checks++; if (n_pop != 20) $display("FAIL wrap_timeout popped=%0d exp=20", n_pop); else n_pass++;
        n_checks++; if (n_cdt != 20) $display("FAIL wrap_cdt_total got=%0d exp=20", n_cdt); else n_pass++;
        n_checks++; if (bus.credit_err !== 1'b0) $display("FAIL wrap_credit_err got=%b exp=0", bus.credit_err); else n_pass++;
        n_checks++; if (dut.reserved_q !== 3'd0) $display("FAIL wrap_reserved got=%0d exp=0", dut.reserved_q); else n_pass++;
    endtask

    task automatic test_simul();
        do_reset();
        repeat (2) tick(1'b1, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b1, 8'hA1, 1'b0);
        tick(1'b0, 1'b1, 8'hA2, 1'b0);
        n_checks++; if (dut.reserved_q !== 3'd2 || dut.count_q !== 3'd2) $display("FAIL simul_pre got=%0d/%0d exp=2/2", dut.reserved_q, dut.count_q); else n_pass++;
        tick(1'b1, 1'b0, 8'h00, 1'b1);
        n_checks++; if (dut.reserved_q !== 3'd2) $display("FAIL simul_reserved got=%0d exp=2", dut.reserved_q); else n_pass++;
        n_checks++; if (dut.count_q !== 3'd1 || bus.cdt_pop !== 1'b1) $display("FAIL simul_count_cdt got=%0d/%b exp=1/1", dut.count_q, bus.cdt_pop); else n_pass++;
        n_checks++; if (bus.rd_pd !== 8'hA2) $display("FAIL simul_head got=%h exp=a2", bus.rd_pd); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (4) tick(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, WIDTH'(8'h40 + i), 1'b0);
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        n_checks++; if (dut.count_q !== 3'd3 || bus.cdt_pop !== 1'b1 || bus.credit_err !== 1'b1)
            $display("FAIL mid_pre got=%0d/%b/%b exp=3/1/1", dut.count_q, bus.cdt_pop, bus.credit_err); else n_pass++;
        bus.rd_prdy = 1'b0;
        #2;
        nvdla_core_rstn = 1'b0;
        #1;
        n_checks++; if (bus.rd_pvld !== 1'b0 || bus.wr_prdy !== 1'b1 || bus.credit_avail !== 1'b1)
            $display("FAIL mid_async_flags got=%b/%b/%b exp=0/1/1", bus.rd_pvld, bus.wr_prdy, bus.credit_avail); else n_pass++;
        n_checks++; if (bus.credit_err !== 1'b0 || bus.cdt_pop !== 1'b0)
            $display("FAIL mid_async_err_cdt got=%b/%b exp=0/0", bus.credit_err, bus.cdt_pop); else n_pass++;
        @(posedge nvdla_core_clk);
        #1;
        nvdla_core_rstn = 1'b1;
        model_reset();
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b1, 8'h5A, 1'b0);
        n_checks++; if (bus.rd_pvld !== 1'b1 || bus.rd_pd !== 8'h5A) $display("FAIL mid_after got=%b/%h exp=1/5a", bus.rd_pvld, bus.rd_pd); else n_pass++;
        n_checks++; if (bus.credit_err !== 1'b0) $display("FAIL mid_after_err got=%b exp=0", bus.credit_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_credit_limit();
        test_full();
        test_wrap();
        test_simul();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
